modulo_controle_transferencia_rolhas: RTL and testbench

Sequencing and arbitration controller for the cork-supply datapath of the bottling line. It owns the secondary (operator-loaded) and primary (sealing-fed) cork stock counters. It serialises two competing requesters onto the shared secondary stock: operator bulk loads and automatic batch refills of the primary stock. It sits between the operator debounced inputs, the filling/sealing FSM (consumption strobe, `ro` flag) and the display encoders (stock values).

---
 rtl/modulo_controle_transferencia_rolhas_pkg.sv | 15 +
 rtl/modulo_controle_transferencia_rolhas_if.sv | 28 ++
 rtl/modulo_controle_transferencia_rolhas_borda.sv | 17 +
 rtl/modulo_controle_transferencia_rolhas.sv | 121 ++++++++++++
 tb/tb_modulo_controle_transferencia_rolhas.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/modulo_controle_transferencia_rolhas_pkg.sv
// Shared constants for the cork-supply controller: state codes, stock width
// and the default capacities and thresholds of the bottling line.
package pkg_rolhas;

    localparam int W_DEF       = 7;
    localparam int MAX_SEC_DEF = 99;
    localparam int MAX_PRI_DEF = 99;
    localparam int MIN_PRI_DEF = 5;
    localparam int LOTE_DEF    = 20;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] CARGA  = 2'b01;
    localparam logic [1:0] TRANSF = 2'b10;

endpackage

// File: rtl/modulo_controle_transferencia_rolhas_if.sv
// Operator / sealer / display signal bundle of the cork-supply controller.
interface modulo_controle_transferencia_rolhas_if
    import pkg_rolhas::*;
#(
    parameter int W = W_DEF
);
    logic         enable;
    logic         op_req;
    logic [W-1:0] op_qtd;
    logic         consome;
    logic [W-1:0] sec_count;
    logic [W-1:0] pri_count;
    logic         ro;
    logic         falta_sec;
    logic         op_rej;
    logic         busy;
    logic [1:0]   estado;

    modport master (
        output enable, op_req, op_qtd, consome,
        input  sec_count, pri_count, ro, falta_sec, op_rej, busy, estado
    );

    modport slave (
        input  enable, op_req, op_qtd, consome,
        output sec_count, pri_count, ro, falta_sec, op_rej, busy, estado
    );
endinterface

// File: rtl/modulo_controle_transferencia_rolhas_borda.sv
// Rising-edge detector for a level input; the pulse is combinational so the
// edge is acted on at the same clock edge that first samples the new level.
module modulo_detector_borda_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);
    logic prev_p0;

    always_ff @(posedge clk) begin
        if (rst) prev_p0 <= 1'b0;
        else     prev_p0 <= din;
    end

    assign pulse = din & ~prev_p0;
endmodule

// File: rtl/modulo_controle_transferencia_rolhas.sv
// Cork-supply sequencer: arbitrates operator bulk loads and automatic primary
// refills over the shared secondary stock, and tracks both stock counters.
module modulo_controle_transferencia_rolhas
    import pkg_rolhas::*;
#(
    parameter int W       = W_DEF,
    parameter int MAX_SEC = MAX_SEC_DEF,
    parameter int MAX_PRI = MAX_PRI_DEF,
    parameter int MIN_PRI = MIN_PRI_DEF,
    parameter int LOTE    = LOTE_DEF
) (
    input  logic clk,
    input  logic rst,
    modulo_controle_transferencia_rolhas_if.slave bus
);
    localparam logic [W-1:0] MIN_W     = W'(MIN_PRI);
    localparam logic [W-1:0] LOTE_W    = W'(LOTE);
    localparam logic [W-1:0] MAX_SEC_W = W'(MAX_SEC);
    localparam logic [W-1:0] MAX_PRI_W = W'(MAX_PRI);
    localparam logic [W:0]   MAX_SEC_X = (W+1)'(MAX_SEC);

    logic [1:0]   state;
    logic [W-1:0] sec_q, pri_q, pri_next, op_rest, xfer;
    logic         op_pend, op_rej_q;
    logic         edge_op, qtd_ok, overflow, occupied, accept, reject;
    logic         ref_req, inc_pri, dec_pri;
    logic [W:0]   sum_op;

    modulo_detector_borda_sync u_borda (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.op_req),
        .pulse (edge_op)
    );

    // Admission of operator loads: zero is silently ignored, overflow or a
    // second request while one is still outstanding is refused.
    assign sum_op   = {1'b0, sec_q} + {1'b0, bus.op_qtd};
    assign qtd_ok   = (bus.op_qtd != '0);
    assign overflow = (sum_op > MAX_SEC_X);
    assign occupied = op_pend || (state == CARGA);
    assign accept   = edge_op && qtd_ok && !occupied && !overflow;
    assign reject   = edge_op && qtd_ok && (occupied || overflow);

    assign ref_req  = bus.enable && (pri_q < MIN_W) && (sec_q >= LOTE_W);

    assign inc_pri  = (state == TRANSF);
    assign dec_pri  = bus.consome && bus.enable && (pri_q != '0);

    always_comb begin
        pri_next = pri_q;
        if (inc_pri && !dec_pri)      pri_next = pri_q + 1'b1;
        else if (!inc_pri && dec_pri) pri_next = pri_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sec_q    <= '0;
            pri_q    <= '0;
            op_pend  <= 1'b0;
            op_rest  <= '0;
            xfer     <= '0;
            op_rej_q <= 1'b0;
        end else begin
            op_rej_q <= reject;
            pri_q    <= pri_next;
            case (state)
                IDLE: begin
                    if (ref_req) begin
                        state <= TRANSF;
                        xfer  <= LOTE_W;
                        if (accept) begin
                            op_pend <= 1'b1;
                            op_rest <= bus.op_qtd;
                        end
                    end else if (op_pend) begin
                        state   <= CARGA;
                        op_pend <= 1'b0;
                    end else if (accept) begin
                        state   <= CARGA;
                        op_rest <= bus.op_qtd;
                    end
                end
                CARGA: begin
                    sec_q   <= sec_q + 1'b1;
                    op_rest <= op_rest - 1'b1;
                    if (op_rest == W'(1)) state <= IDLE;
                end
                TRANSF: begin
                    sec_q <= sec_q - 1'b1;
                    xfer  <= xfer - 1'b1;
                    if (xfer == W'(1)) state <= IDLE;
                    // A load arriving mid-refill waits latched for the next IDLE.
                    if (accept) begin
                        op_pend <= 1'b1;
                        op_rest <= bus.op_qtd;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((sec_q <= MAX_SEC_W) && (pri_q <= MAX_PRI_W) &&
                    !((state == CARGA) && (sec_q == MAX_SEC_W)) &&
                    !((state == TRANSF) && ((sec_q == '0) || (pri_q == MAX_PRI_W))));
        end
    end

    assign bus.sec_count = sec_q;
    assign bus.pri_count = pri_q;
    assign bus.ro        = (pri_q == '0);
    // Shortage is only reported while the line is running.
    assign bus.falta_sec = bus.enable && (pri_q < MIN_W) && (sec_q < LOTE_W);
    assign bus.op_rej    = op_rej_q;
    assign bus.busy      = (state != IDLE);
    assign bus.estado    = state;
endmodule

// File: tb/tb_modulo_controle_transferencia_rolhas.sv
// Directed bench for the cork-supply controller with a queue of expected
// stock values checked whenever an operation returns to IDLE.
module tb_modulo_controle_transferencia_rolhas;
    logic clk = 1'b0;
    logic rst;

    modulo_controle_transferencia_rolhas_if #(.W(7)) bus ();

    modulo_controle_transferencia_rolhas #(.W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    sec;
        int    pri;
        int    cycles;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic push_exp(input string tag, input int sec, input int pri, input int cycles);
        exp_t e;
        e.tag = tag; e.sec = sec; e.pri = pri; e.cycles = cycles;
        sb.push_back(e);
    endtask

    task automatic pulse_req(input int qtd);
        bus.op_qtd = 7'(qtd);
        bus.op_req = 1'b1;
        @(negedge clk);
        bus.op_req = 1'b0;
    endtask

    task automatic run_op(input int consome_at);
        exp_t e;
        int   c = 0;
        while (bus.busy === 1'b1 && c < 300) begin
            c++;
            bus.consome = (c == consome_at);
            @(negedge clk);
        end
        bus.consome = 1'b0;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_cycles"}, c, e.cycles);
            check({e.tag, "_sec"}, int'(bus.sec_count), e.sec);
            check({e.tag, "_pri"}, int'(bus.pri_count), e.pri);
            check({e.tag, "_ro"}, int'(bus.ro), (e.pri == 0) ? 1 : 0);
        end
    endtask

    task automatic consume(input int n);
        for (int i = 0; i < n; i++) begin
            bus.consome = 1'b1;
            @(negedge clk);
        end
        bus.consome = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sec"}, int'(bus.sec_count), 0);
        check({tag, "_pri"}, int'(bus.pri_count), 0);
        check({tag, "_ro"}, int'(bus.ro), 1);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_estado"}, int'(bus.estado), 0);
        check({tag, "_falta"}, int'(bus.falta_sec), 0);
        check({tag, "_rej"}, int'(bus.op_rej), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.op_req = 1'b0;
        bus.op_qtd = '0;
        bus.consome = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Operator load of 30 with the line stopped
        push_exp("load30", 30, 0, 30);
        pulse_req(30);
        check("load30_estado", int'(bus.estado), 1);
        run_op(-1);

        // Refill from empty primary, one cork consumed at transfer cycle 5
        bus.enable = 1'b1;
        @(negedge clk);
        check("refill1_estado", int'(bus.estado), 2);
        push_exp("refill1", 10, 19, 20);
        run_op(5);

        // Drain primary to 3 with too little secondary stock
        consume(16);
        check("short_pri", int'(bus.pri_count), 3);
        check("short_falta", int'(bus.falta_sec), 1);
        push_exp("load2", 12, 3, 2);
        pulse_req(2);
        run_op(-1);
        @(negedge clk);
        check("short_no_transf", int'(bus.estado), 0);
        check("short_falta2", int'(bus.falta_sec), 1);

        // Load 10 unlocks the refill right after the load ends
        push_exp("load10", 22, 3, 10);
        pulse_req(10);
        run_op(-1);
        @(negedge clk);
        check("refill2_estado", int'(bus.estado), 2);
        push_exp("refill2", 2, 23, 20);
        run_op(-1);
        check("refill2_falta", int'(bus.falta_sec), 0);

        // Fill to 90, then an overflowing request is refused
        push_exp("load88", 90, 23, 88);
        pulse_req(88);
        run_op(-1);
        pulse_req(15);
        check("rej_pulse", int'(bus.op_rej), 1);
        check("rej_estado", int'(bus.estado), 0);
        check("rej_busy", int'(bus.busy), 0);
        @(negedge clk);
        check("rej_one_cycle", int'(bus.op_rej), 0);
        check("rej_sec", int'(bus.sec_count), 90);
        pulse_req(0);
        check("zero_no_rej", int'(bus.op_rej), 0);
        check("zero_no_busy", int'(bus.busy), 0);

        // Refill condition and operator edge at the same clock edge
        consume(19);
        check("simul_pri", int'(bus.pri_count), 4);
        check("simul_idle", int'(bus.estado), 0);
        push_exp("simul_refill", 70, 24, 20);
        pulse_req(5);
        check("simul_transf_first", int'(bus.estado), 2);
        run_op(-1);
        @(negedge clk);
        check("simul_carga_next", int'(bus.estado), 1);
        check("simul_carga_sec0", int'(bus.sec_count), 70);
        repeat (2) @(negedge clk);
        check("simul_carga_sec2", int'(bus.sec_count), 72);

        // Reset in the middle of the pending load
        rst = 1'b1;
        bus.enable = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_idle", int'(bus.busy), 0);
        check("after_rst_sec", int'(bus.sec_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
